vid_mem_port: RTL and testbench
===============================

VID_MEM_PORT -- requirements
Module: vid_mem_port

Interface
REQ-001 SHALL have parameter DATA_W, default 8, CPU/PPU data width.
REQ-002 SHALL have parameter ADDR_W, default 16, CPU address width.
REQ-003 SHALL have parameter VRAM_BASE, default 16'h8000, first VRAM byte address.
REQ-004 SHALL have parameter VRAM_DEPTH, default 8192, VRAM entries (power of two).
REQ-005 SHALL have parameter OAM_BASE, default 16'hFE00, first OAM byte address.
REQ-006 SHALL have parameter OAM_DEPTH, default 160, OAM entries; OAM window spans 256 addresses.
REQ-007 Ports, one clock; reset is synchronous and active-high:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_we  in  1  CPU write strobe, one cycle
- cpu_re  in  1  CPU read strobe, one cycle
- cpu_rdata  out  DATA_W  CPU read data
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_hit  out  1  registered: last strobe decoded to VRAM or OAM window
- ppu_mode  in  2  0 HBLANK, 1 VBLANK, 2 OAM scan, 3 transfer
- ppu_vram_addr  in  $clog2(VRAM_DEPTH)  PPU VRAM index
- ppu_vram_rdata  out  DATA_W  PPU VRAM data
- ppu_oam_addr  in  8  PPU OAM index
- ppu_oam_rdata  out  DATA_W  PPU OAM data
- blocked_cnt  out  8  saturating count of locked-out CPU accesses

Function
REQ-008 SHALL decode VRAM hit as VRAM_BASE <= cpu_addr < VRAM_BASE+VRAM_DEPTH; OAM hit as OAM_BASE <= cpu_addr < OAM_BASE+256.
REQ-009 CPU reads SHALL have 1-cycle latency: strobe in cycle N -> cpu_rvalid=1 with data in N+1 only; cpu_rvalid=0 otherwise.
REQ-010 CPU read outside both windows SHALL give cpu_rvalid=0, cpu_hit=0 next cycle.
REQ-011 CPU write to hit region SHALL update storage at clock edge; read in next cycle returns new value.
REQ-012 OAM addresses OAM_BASE+OAM_DEPTH..OAM_BASE+255: reads return 0 with cpu_rvalid=1; writes ignored.
REQ-013 cpu_we and cpu_re together: write performed, no read, cpu_rvalid=0 next cycle.
REQ-014 PPU ports SHALL be independent 1-cycle-latency reads every cycle, never stalled by CPU traffic.
REQ-015 Same-cycle CPU write and PPU read of same location: PPU gets old data.
REQ-016 Lockout (when compiled in): ppu_mode=3 blocks CPU VRAM and OAM; ppu_mode=2 blocks CPU OAM only; ppu_mode sampled in strobe cycle.
REQ-017 Blocked read SHALL return all-ones with cpu_rvalid=1; blocked write SHALL be dropped, storage unchanged.
REQ-018 Each blocked strobe SHALL increment blocked_cnt by 1, saturating at 255.

Reset
REQ-019 rst SHALL clear cpu_rvalid, cpu_hit, cpu_rdata, ppu_vram_rdata, ppu_oam_rdata, blocked_cnt to 0.
REQ-020 rst SHALL NOT clear VRAM/OAM contents.
REQ-021 Strobe in same cycle as rst SHALL be discarded: no write, no rvalid.

Configuration
REQ-022 Macro VID_MEM_LOCKOUT_EN: defined -> REQ-016..REQ-018 active; undefined -> CPU never blocked, blocked_cnt tied 0.

Verification
REQ-023 Write 8'hA5 to 16'hFE00 mode 0, read back -> cpu_rvalid=1, cpu_rdata=8'hA5 next cycle.
REQ-024 Write 8'h3C to 16'h9FFF mode 0; set mode 3, read -> 8'hFF, blocked_cnt=1; mode 1 read -> 8'h3C.
REQ-025 Mode 2: write 8'h11 to 16'h8000 and 8'h22 to 16'hFE01 -> VRAM=8'h11, OAM[1] unchanged, blocked_cnt=1.
REQ-026 Read 16'hFEA0 -> 0, rvalid=1; read 16'hC000 -> rvalid=0, cpu_hit=0.
REQ-027 300 blocked accesses in mode 3 -> blocked_cnt=255; rst -> 0, prior VRAM data intact.
REQ-028 Random fill all VRAM/OAM in mode 1, compare via CPU and PPU ports -> zero mismatches.

Source files
------------

// File: rtl/vid_mem_port.sv
// vid_mem_port: CPU/PPU shared video memory port (VRAM + OAM).
// The CPU side decodes byte addresses into the VRAM and OAM windows with a
// 1-cycle registered read. Each PPU port reads every cycle, also with 1-cycle
// latency. Optional mode-based CPU lockout is compiled in by defining
// VID_MEM_LOCKOUT_EN. Without it the CPU is never blocked and blocked_cnt is 0.
module vid_mem_port #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned VRAM_BASE  = 16'h8000,
  parameter int unsigned VRAM_DEPTH = 8192,
  parameter int unsigned OAM_BASE   = 16'hFE00,
  parameter int unsigned OAM_DEPTH  = 160
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  input  logic                          cpu_we,
  input  logic                          cpu_re,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          cpu_rvalid,
  output logic                          cpu_hit,
  input  logic [1:0]                    ppu_mode,
  input  logic [$clog2(VRAM_DEPTH)-1:0] ppu_vram_addr,
  output logic [DATA_W-1:0]             ppu_vram_rdata,
  input  logic [7:0]                    ppu_oam_addr,
  output logic [DATA_W-1:0]             ppu_oam_rdata,
  output logic [7:0]                    blocked_cnt
);

  localparam int unsigned VA_W = $clog2(VRAM_DEPTH);
  localparam int unsigned OA_W = $clog2(OAM_DEPTH);
  localparam logic [ADDR_W-1:0] VRAM_BASE_A = ADDR_W'(VRAM_BASE);
  localparam logic [ADDR_W-1:0] OAM_BASE_A  = ADDR_W'(OAM_BASE);
  // Window ends computed in 32 bits so a window touching the top of the
  // address space cannot wrap.
  localparam int unsigned VRAM_END = VRAM_BASE + VRAM_DEPTH;
  localparam int unsigned OAM_END  = OAM_BASE + 256;

  logic [DATA_W-1:0] vram [VRAM_DEPTH];
  logic [DATA_W-1:0] oam  [OAM_DEPTH];

  logic [31:0]     addr_ext;
  logic            vram_hit;
  logic            oam_hit;
  logic            oam_in_range;
  logic [VA_W-1:0] vram_idx;
  logic [7:0]      oam_off;
  logic            blocked;
  logic            strobe;
  logic            rd_go;
  logic            wr_vram;
  logic            wr_oam;

  assign addr_ext     = 32'(cpu_addr);
  assign vram_hit     = (addr_ext >= VRAM_BASE) && (addr_ext < VRAM_END);
  assign oam_hit      = (addr_ext >= OAM_BASE) && (addr_ext < OAM_END);
  assign vram_idx     = VA_W'(cpu_addr - VRAM_BASE_A);
  assign oam_off      = 8'(cpu_addr - OAM_BASE_A);
  // The top of the OAM window past the populated entries reads as 0.
  assign oam_in_range = (32'(oam_off) < OAM_DEPTH);

`ifdef VID_MEM_LOCKOUT_EN
  // Transfer mode owns both memories; OAM scan owns OAM only.
  assign blocked = (vram_hit && (ppu_mode == 2'd3)) || (oam_hit && ppu_mode[1]);
`else
  logic unused_mode;
  assign unused_mode = ^ppu_mode;
  assign blocked     = 1'b0;
`endif

  // A strobe coinciding with reset is discarded entirely.
  assign strobe  = (cpu_we || cpu_re) && !rst;
  // Write wins over read when both strobes are raised together.
  assign rd_go   = cpu_re && !cpu_we && (vram_hit || oam_hit);
  assign wr_vram = cpu_we && !rst && !blocked && vram_hit;
  assign wr_oam  = cpu_we && !rst && !blocked && oam_hit && oam_in_range;

  // Memory write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_vram) vram[vram_idx] <= cpu_wdata;
    if (wr_oam)  oam[oam_off[OA_W-1:0]] <= cpu_wdata;
  end

  // CPU registered read path, hit flag and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      cpu_hit    <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      cpu_rvalid <= rd_go;
      if (strobe) cpu_hit <= vram_hit || oam_hit;
      if (rd_go) begin
        if (blocked)           cpu_rdata <= '1;
        else if (vram_hit)     cpu_rdata <= vram[vram_idx];
        else if (oam_in_range) cpu_rdata <= oam[oam_off[OA_W-1:0]];
        else                   cpu_rdata <= '0;
      end
    end
  end

  // PPU read ports: free-running, old data on a same-cycle CPU write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ppu_vram_rdata <= '0;
      ppu_oam_rdata  <= '0;
    end else begin
      ppu_vram_rdata <= vram[ppu_vram_addr];
      if (32'(ppu_oam_addr) < OAM_DEPTH) ppu_oam_rdata <= oam[ppu_oam_addr[OA_W-1:0]];
      else                               ppu_oam_rdata <= '0;
    end
  end

`ifdef VID_MEM_LOCKOUT_EN
  logic [7:0] cnt_reg;

  // Saturating count of CPU strobes refused by the lockout.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 8'd0;
    end else if (strobe && blocked && (cnt_reg != 8'hFF)) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign blocked_cnt = cnt_reg;
`else
  assign blocked_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vid_mem_port.sv
// tb_vid_mem_port: directed tests plus a per-cycle reference model check
// for vid_mem_port. Expectations on lockout follow VID_MEM_LOCKOUT_EN.
module tb_vid_mem_port;

`ifdef VID_MEM_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_hit;
  logic [1:0]  ppu_mode;
  logic [12:0] ppu_vram_addr;
  logic [7:0]  ppu_vram_rdata;
  logic [7:0]  ppu_oam_addr;
  logic [7:0]  ppu_oam_rdata;
  logic [7:0]  blocked_cnt;

  vid_mem_port dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_hit(cpu_hit),
    .ppu_mode(ppu_mode),
    .ppu_vram_addr(ppu_vram_addr), .ppu_vram_rdata(ppu_vram_rdata),
    .ppu_oam_addr(ppu_oam_addr), .ppu_oam_rdata(ppu_oam_rdata),
    .blocked_cnt(blocked_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;
  bit verbose  = 1'b1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] vram_m [8192];
  bit         vk     [8192];
  logic [7:0] oam_m  [160];
  bit         ok_m   [160];

  logic       exp_rvalid, exp_hit, exp_rd_chk, exp_pv_chk, exp_po_chk;
  logic [7:0] exp_rdata, exp_pv, exp_po, exp_cnt;
  int         m_a;
  bit         m_inv, m_ino, m_blk, m_stb;

  // Outputs the DUT must show after each edge, derived from the rules.
  always @(posedge clk) begin
    if (rst) begin
      exp_rvalid = 0; exp_hit = 0; exp_rd_chk = 1; exp_rdata = 8'h00; exp_cnt = 8'h00;
      exp_pv_chk = 1; exp_pv = 8'h00; exp_po_chk = 1; exp_po = 8'h00;
    end else begin
      exp_pv_chk = vk[ppu_vram_addr];
      exp_pv     = vram_m[ppu_vram_addr];
      if (ppu_oam_addr < 8'd160) begin
        exp_po_chk = ok_m[ppu_oam_addr]; exp_po = oam_m[ppu_oam_addr];
      end else begin
        exp_po_chk = 1; exp_po = 8'h00;
      end
      m_a   = int'(cpu_addr);
      m_inv = (m_a >= 'h8000) && (m_a < 'hA000);
      m_ino = (m_a >= 'hFE00) && (m_a < 'hFF00);
      m_blk = LOCK && ((m_inv && ppu_mode == 2'd3) || (m_ino && ppu_mode >= 2'd2));
      m_stb = cpu_we || cpu_re;
      if (m_stb) exp_hit = m_inv || m_ino;
      exp_rvalid = cpu_re && !cpu_we && (m_inv || m_ino);
      exp_rd_chk = exp_rvalid;
      if (exp_rvalid) begin
        if (m_blk) exp_rdata = 8'hFF;
        else if (m_inv) begin
          exp_rd_chk = vk[m_a - 'h8000]; exp_rdata = vram_m[m_a - 'h8000];
        end else if (m_a - 'hFE00 < 160) begin
          exp_rd_chk = ok_m[m_a - 'hFE00]; exp_rdata = oam_m[m_a - 'hFE00];
        end else exp_rdata = 8'h00;
      end
      if (m_stb && m_blk && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      if (cpu_we && !m_blk) begin
        if (m_inv) begin
          vram_m[m_a - 'h8000] = cpu_wdata; vk[m_a - 'h8000] = 1;
        end else if (m_ino && (m_a - 'hFE00 < 160)) begin
          oam_m[m_a - 'hFE00] = cpu_wdata; ok_m[m_a - 'hFE00] = 1;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("rvalid", {7'd0, cpu_rvalid}, {7'd0, exp_rvalid});
      chk("hit", {7'd0, cpu_hit}, {7'd0, exp_hit});
      if (exp_rd_chk) chk("rdata", cpu_rdata, exp_rdata);
      if (exp_pv_chk) chk("ppu_vram", ppu_vram_rdata, exp_pv);
      if (exp_po_chk) chk("ppu_oam", ppu_oam_rdata, exp_po);
      chk("blocked_cnt", blocked_cnt, exp_cnt);
    end
  end

  // ---------------- stimulus ----------------
  // One CPU strobe; returns just after the edge that produced its result.
  task automatic strobe(input logic [15:0] a, input logic [7:0] d,
                        input logic we, input logic re, input logic [1:0] mode);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_we = we; cpu_re = re; ppu_mode = mode;
    ppu_vram_addr = 13'($urandom); ppu_oam_addr = 8'($urandom);
    @(negedge clk);
    cpu_we = 0; cpu_re = 0;
    if (verbose)
      $display("txn addr=%04h we=%0b re=%0b wdata=%02h mode=%0d -> rvalid=%0b rdata=%02h hit=%0b cnt=%0d",
               a, we, re, d, mode, cpu_rvalid, cpu_rdata, cpu_hit, blocked_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  initial begin
    rst = 1; cpu_addr = 0; cpu_wdata = 0; cpu_we = 0; cpu_re = 0;
    ppu_mode = 0; ppu_vram_addr = 0; ppu_oam_addr = 0;
    @(negedge clk); @(negedge clk);
    started = 1;
    // Reset state
    chk("rst_rvalid", {7'd0, cpu_rvalid}, 8'h00);
    chk("rst_hit", {7'd0, cpu_hit}, 8'h00);
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_ppu_vram", ppu_vram_rdata, 8'h00);
    chk("rst_ppu_oam", ppu_oam_rdata, 8'h00);
    chk("rst_cnt", blocked_cnt, 8'h00);
    rst = 0;

    // OAM write then read back
    strobe(16'hFE00, 8'hA5, 1, 0, 2'd0);
    strobe(16'hFE00, 8'h00, 0, 1, 2'd0);
    chk("oam_rb_valid", {7'd0, cpu_rvalid}, 8'h01);
    chk("oam_rb_data", cpu_rdata, 8'hA5);

    // Last VRAM byte, then lockout in transfer mode
    strobe(16'h9FFF, 8'h3C, 1, 0, 2'd0);
    strobe(16'h9FFF, 8'h00, 0, 1, 2'd3);
    chk("m3_read", cpu_rdata, LOCK ? 8'hFF : 8'h3C);
    chk("m3_cnt", blocked_cnt, LOCK ? 8'd1 : 8'd0);
    strobe(16'h9FFF, 8'h00, 0, 1, 2'd1);
    chk("m1_read", cpu_rdata, 8'h3C);

    // OAM scan mode blocks OAM only
    do_reset();
    strobe(16'hFE01, 8'h5A, 1, 0, 2'd0);
    strobe(16'h8000, 8'h11, 1, 0, 2'd2);
    strobe(16'hFE01, 8'h22, 1, 0, 2'd2);
    chk("m2_cnt", blocked_cnt, LOCK ? 8'd1 : 8'd0);
    strobe(16'h8000, 8'h00, 0, 1, 2'd1);
    chk("m2_vram", cpu_rdata, 8'h11);
    strobe(16'hFE01, 8'h00, 0, 1, 2'd1);
    chk("m2_oam1", cpu_rdata, LOCK ? 8'h5A : 8'h22);

    // Unpopulated OAM tail and unmapped address
    strobe(16'hFEA0, 8'h00, 0, 1, 2'd0);
    chk("oam_tail_valid", {7'd0, cpu_rvalid}, 8'h01);
    chk("oam_tail_data", cpu_rdata, 8'h00);
    strobe(16'hFEA0, 8'h99, 1, 0, 2'd0);
    strobe(16'hFEA0, 8'h00, 0, 1, 2'd0);
    chk("oam_tail_wr", cpu_rdata, 8'h00);
    strobe(16'hC000, 8'h00, 0, 1, 2'd0);
    chk("miss_valid", {7'd0, cpu_rvalid}, 8'h00);
    chk("miss_hit", {7'd0, cpu_hit}, 8'h00);

    // Write and read together: write only
    strobe(16'h8001, 8'h66, 1, 1, 2'd0);
    chk("we_re_valid", {7'd0, cpu_rvalid}, 8'h00);
    strobe(16'h8001, 8'h00, 0, 1, 2'd0);
    chk("we_re_data", cpu_rdata, 8'h66);

    // PPU sees old data on a same-cycle write
    @(negedge clk);
    cpu_addr = 16'h8001; cpu_wdata = 8'h77; cpu_we = 1; ppu_vram_addr = 13'd1; ppu_mode = 2'd0;
    @(negedge clk);
    cpu_we = 0;
    chk("ppu_old", ppu_vram_rdata, 8'h66);
    @(negedge clk);
    chk("ppu_new", ppu_vram_rdata, 8'h77);

    // Saturation, then reset keeps memory
    verbose = 0;
    for (int i = 0; i < 300; i++) strobe(16'h9FFF, 8'h00, 0, 1, 2'd3);
    verbose = 1;
    chk("sat_cnt", blocked_cnt, LOCK ? 8'hFF : 8'h00);
    do_reset();
    chk("sat_rst_cnt", blocked_cnt, 8'h00);
    strobe(16'h9FFF, 8'h00, 0, 1, 2'd1);
    chk("rst_keeps_vram", cpu_rdata, 8'h3C);

    // Strobe during reset is discarded
    @(negedge clk);
    rst = 1; cpu_addr = 16'h8000; cpu_wdata = 8'hEE; cpu_we = 1; cpu_re = 1;
    @(negedge clk);
    rst = 0; cpu_we = 0; cpu_re = 0;
    chk("rst_strobe_valid", {7'd0, cpu_rvalid}, 8'h00);
    strobe(16'h8000, 8'h00, 0, 1, 2'd1);
    chk("rst_strobe_nowr", cpu_rdata, 8'h11);

    // Random fill of all storage in VBLANK, then read back
    verbose = 0;
    for (int i = 0; i < 8192; i++) strobe(16'(16'h8000 + i), 8'($urandom), 1, 0, 2'd1);
    for (int i = 0; i < 160; i++)  strobe(16'(16'hFE00 + i), 8'($urandom), 1, 0, 2'd1);
    for (int i = 0; i < 8192; i++) strobe(16'(16'h8000 + i), 8'h00, 0, 1, 2'd1);
    for (int i = 0; i < 256; i++)  strobe(16'(16'hFE00 + i), 8'h00, 0, 1, 2'd1);
    verbose = 1;
    $display("fill/readback done");

    @(negedge clk);
    started = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
